mul_ctrl: RTL and testbench

//  EX-stage front end for the iterative multiplier `mul`. Decodes RV32M MUL/MULH/MULHSU/MULHU,

---
 rtl/mul_ctrl_pkg.sv | 31 +++
 rtl/mul_ctrl_sign_fix.sv | 14 +
 rtl/mul_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mul_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types for the RV32M multiply front end: opcodes, FSM states and product classes.
package mul_ctrl_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      MUL_CTRL_IDLE = 2'b00,
      MUL_CTRL_BUSY = 2'b01,
      MUL_CTRL_DONE = 2'b10
   } mul_state_e;

   typedef enum logic [1:0] {
      MUL_CLS_SS = 2'b00,
      MUL_CLS_UU = 2'b01,
      MUL_CLS_SU = 2'b10
   } mul_class_e;

   function automatic mul_class_e op_class(mul_op_e op);
      case (op)
         MUL_OP_MULHU:  return MUL_CLS_UU;
         MUL_OP_MULHSU: return MUL_CLS_SU;
         default:       return MUL_CLS_SS;
      endcase
   endfunction

endpackage

// File: rtl/mul_ctrl_sign_fix.sv
// Combinational MULHSU helpers: magnitude of rs1 and conditional 64-bit two's-complement negate.
module mul_ctrl_sign_fix (
   input  logic [31:0] op1_i,
   input  logic [63:0] prod_i,
   input  logic        neg_i,
   output logic [31:0] op1_abs_o,
   output logic [63:0] prod_o
);

   // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
   assign op1_abs_o = op1_i[31] ? (~op1_i + 32'd1) : op1_i;
   assign prod_o    = neg_i ? (~prod_i + 64'd1) : prod_i;

endmodule

// File: rtl/mul_ctrl.sv
// EX-stage control for the iterative multiplier: decode, handshake, stall, sign fix, writeback.
// Optional result reuse of the last completed product is enabled by defining MUL_RESULT_REUSE_EN.
module mul_ctrl
   import mul_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mul_req_i,
   input  logic [1:0]  ex_mul_op_i,
   input  logic [31:0] ex_op1_i,
   input  logic [31:0] ex_op2_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        flush_i,
   input  logic        mul_stop_i,
   input  logic [31:0] mul_res_l_i,
   input  logic [31:0] mul_res_h_i,
   output logic        mul_start_o,
   output logic        mul_cancel_o,
   output logic        mul_signed_o,
   output logic [31:0] mul_op1_o,
   output logic [31:0] mul_op2_o,
   output logic        stall_req_o,
   output logic        wb_we_o,
   output logic [4:0]  wb_rd_addr_o,
   output logic [31:0] wb_data_o
);

   mul_state_e  state_q;
   mul_op_e     op_q;
   mul_op_e     req_op;
   logic [4:0]  rd_q;
   logic        neg_q;
   logic        start_q;
   logic        cancel_q;
   logic        signed_q;
   logic [31:0] op1_q;
   logic [31:0] op2_q;
   logic [63:0] prod_q;
   logic [31:0] wb_data_q;
   logic [4:0]  wb_rd_q;

   logic        req_take;
   logic        signed_d;
   logic        neg_d;
   logic [31:0] op1_d;
   logic [31:0] op1_abs;
   logic [63:0] prod_fix;
   logic [31:0] wb_sel;
   logic        reuse_hit;
   logic [63:0] reuse_prod;

   assign req_op   = mul_op_e'(ex_mul_op_i);
   assign req_take = (state_q == MUL_CTRL_IDLE) && ex_mul_req_i && !flush_i;

   mul_ctrl_sign_fix u_sign_fix (
      .op1_i     (ex_op1_i),
      .prod_i    ({mul_res_h_i, mul_res_l_i}),
      .neg_i     (neg_q),
      .op1_abs_o (op1_abs),
      .prod_o    (prod_fix)
   );

   // MULHSU runs as |rs1| x rs2 unsigned, then the product is negated if rs1 was negative.
   assign signed_d = (req_op == MUL_OP_MUL) || (req_op == MUL_OP_MULH);
   assign neg_d    = (req_op == MUL_OP_MULHSU) && ex_op1_i[31];
   assign op1_d    = (req_op == MUL_OP_MULHSU) ? op1_abs : ex_op1_i;

`ifdef MUL_RESULT_REUSE_EN
   logic        ent_vld_q;
   mul_class_e  ent_cls_q;
   logic [31:0] ent_op1_q;
   logic [31:0] ent_op2_q;
   logic [63:0] ent_prod_q;
   logic [31:0] raw_op1_q;
   logic [31:0] raw_op2_q;
   logic        ent_wr;

   assign ent_wr     = (state_q == MUL_CTRL_BUSY) && mul_stop_i && !flush_i;
   // MUL only needs the low word, which is identical for every product class.
   assign reuse_hit  = ent_vld_q && (ent_op1_q == ex_op1_i) && (ent_op2_q == ex_op2_i) &&
                       ((req_op == MUL_OP_MUL) || (op_class(req_op) == ent_cls_q));
   assign reuse_prod = ent_prod_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_vld_q <= 1'b0;
      end else if (ent_wr) begin
         ent_vld_q <= 1'b1;
      end
   end

   // NOTE: the entry payload is qualified by ent_vld_q, so it needs no reset of its own.
   always_ff @(posedge clk) begin
      if (req_take) begin
         raw_op1_q <= ex_op1_i;
         raw_op2_q <= ex_op2_i;
      end
      if (ent_wr) begin
         ent_cls_q  <= op_class(op_q);
         ent_op1_q  <= raw_op1_q;
         ent_op2_q  <= raw_op2_q;
         ent_prod_q <= prod_fix;
      end
   end
`else
   assign reuse_hit  = 1'b0;
   assign reuse_prod = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MUL_CTRL_IDLE;
         op_q      <= MUL_OP_MUL;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         start_q   <= 1'b0;
         cancel_q  <= 1'b0;
         signed_q  <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         prod_q    <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
      end else begin
         cancel_q <= 1'b0;
         case (state_q)
            MUL_CTRL_IDLE: begin
               if (req_take) begin
                  op_q <= req_op;
                  rd_q <= ex_rd_addr_i;
                  if (reuse_hit) begin
                     prod_q  <= reuse_prod;
                     state_q <= MUL_CTRL_DONE;
                  end else begin
                     start_q  <= 1'b1;
                     signed_q <= signed_d;
                     neg_q    <= neg_d;
                     op1_q    <= op1_d;
                     op2_q    <= ex_op2_i;
                     state_q  <= MUL_CTRL_BUSY;
                  end
               end
            end
            MUL_CTRL_BUSY: begin
               if (flush_i) begin
                  cancel_q <= 1'b1;
                  start_q  <= 1'b0;
                  state_q  <= MUL_CTRL_IDLE;
               end else if (mul_stop_i) begin
                  prod_q  <= prod_fix;
                  start_q <= 1'b0;
                  state_q <= MUL_CTRL_DONE;
               end
            end
            default: state_q <= MUL_CTRL_IDLE;
         endcase
         if (wb_we_o) begin
            wb_data_q <= wb_sel;
            wb_rd_q   <= rd_q;
         end
      end
   end

   assign wb_sel       = (op_q == MUL_OP_MUL) ? prod_q[31:0] : prod_q[63:32];
   assign wb_we_o      = (state_q == MUL_CTRL_DONE) && !flush_i;
   assign wb_data_o    = wb_we_o ? wb_sel : wb_data_q;
   assign wb_rd_addr_o = wb_we_o ? rd_q : wb_rd_q;
   assign stall_req_o  = req_take || (state_q == MUL_CTRL_BUSY);
   assign mul_start_o  = start_q;
   assign mul_cancel_o = cancel_q;
   assign mul_signed_o = signed_q;
   assign mul_op1_o    = op1_q;
   assign mul_op2_o    = op2_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed cases plus randomized ops against an arithmetic model.
module tb_mul_ctrl;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mul_req_i;
   logic [1:0]  ex_mul_op_i;
   logic [31:0] ex_op1_i;
   logic [31:0] ex_op2_i;
   logic [4:0]  ex_rd_addr_i;
   logic        flush_i;
   logic        mul_stop_i;
   logic [31:0] mul_res_l_i;
   logic [31:0] mul_res_h_i;
   logic        mul_start_o;
   logic        mul_cancel_o;
   logic        mul_signed_o;
   logic [31:0] mul_op1_o;
   logic [31:0] mul_op2_o;
   logic        stall_req_o;
   logic        wb_we_o;
   logic [4:0]  wb_rd_addr_o;
   logic [31:0] wb_data_o;

   mul_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ex_mul_req_i (ex_mul_req_i),
      .ex_mul_op_i  (ex_mul_op_i),
      .ex_op1_i     (ex_op1_i),
      .ex_op2_i     (ex_op2_i),
      .ex_rd_addr_i (ex_rd_addr_i),
      .flush_i      (flush_i),
      .mul_stop_i   (mul_stop_i),
      .mul_res_l_i  (mul_res_l_i),
      .mul_res_h_i  (mul_res_h_i),
      .mul_start_o  (mul_start_o),
      .mul_cancel_o (mul_cancel_o),
      .mul_signed_o (mul_signed_o),
      .mul_op1_o    (mul_op1_o),
      .mul_op2_o    (mul_op2_o),
      .stall_req_o  (stall_req_o),
      .wb_we_o      (wb_we_o),
      .wb_rd_addr_o (wb_rd_addr_o),
      .wb_data_o    (wb_data_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] last_data;
   logic [4:0]  last_rd;
   logic        ent_vld;
   logic [31:0] ent_a;
   logic [31:0] ent_b;
   int          ent_cls;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      case (op)
         OP_MULH:   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         OP_MULHSU: p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
         default:   p = {32'd0, a} * {32'd0, b};
      endcase
      return (op == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] ref_op1(input logic [1:0] op, input logic [31:0] a);
      return (op == OP_MULHSU && a[31]) ? (32'd0 - a) : a;
   endfunction

   function automatic logic ref_signed(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

   function automatic int op_cls(input logic [1:0] op);
      return (op == OP_MULHU) ? 1 : (op == OP_MULHSU) ? 2 : 0;
   endfunction

   function automatic logic model_hit(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      logic en;
`ifdef MUL_RESULT_REUSE_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      return en && ent_vld && (ent_a == a) && (ent_b == b) && (op == OP_MUL || op_cls(op) == ent_cls);
   endfunction

   // Behaviour of the external multiplier: full 64-bit product of the presented operands.
   function automatic logic [63:0] mul_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
      if (s) return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return {32'd0, x} * {32'd0, y};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // flush_at: 0 none, 1..lat flush in that BUSY cycle (lat = with mul_stop_i), lat+1 flush in DONE.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int flush_at);
      logic        hit;
      logic [31:0] exp;
      logic [63:0] p;
      hit = model_hit(op, a, b);
      exp = ref_result(op, a, b);

      next_cycle();
      ex_mul_req_i = 1'b1; ex_mul_op_i = op; ex_op1_i = a; ex_op2_i = b; ex_rd_addr_i = rd;
      flush_i = 1'b0; mul_stop_i = 1'b0;
      @(negedge clk);
      check("stall_on_req", stall_req_o, 1);
      check("start_on_req", mul_start_o, 0);
      check("we_on_req", wb_we_o, 0);

      if (hit) begin
         next_cycle();
         @(negedge clk);
         check("reuse_no_start", mul_start_o, 0);
         check("reuse_we", wb_we_o, 1);
         check("reuse_data", wb_data_o, exp);
         check("reuse_rd", wb_rd_addr_o, rd);
         check("reuse_stall", stall_req_o, 0);
         last_data = exp; last_rd = rd;
         next_cycle();
         ex_mul_req_i = 1'b0;
         @(negedge clk);
         check("reuse_we_drop", wb_we_o, 0);
         check("reuse_hold", wb_data_o, last_data);
         return;
      end

      for (int k = 1; k <= lat; k++) begin
         next_cycle();
         if (k == lat) begin
            p = mul_prod(mul_op1_o, mul_op2_o, mul_signed_o);
            mul_stop_i = 1'b1; mul_res_l_i = p[31:0]; mul_res_h_i = p[63:32];
         end
         if (k == flush_at) begin
            flush_i = 1'b1; ex_mul_req_i = 1'b0;
         end
         @(negedge clk);
         check("busy_start", mul_start_o, 1);
         check("busy_stall", stall_req_o, 1);
         check("busy_we", wb_we_o, 0);
         if (k == 1) begin
            check("op1", mul_op1_o, ref_op1(op, a));
            check("op2", mul_op2_o, b);
            check("signed", mul_signed_o, ref_signed(op));
         end
         if (k == flush_at) break;
      end

      if (flush_at >= 1 && flush_at <= lat) begin
         next_cycle();
         flush_i = 1'b0; mul_stop_i = 1'b0;
         @(negedge clk);
         check("cancel_pulse", mul_cancel_o, 1);
         check("cancel_start", mul_start_o, 0);
         check("cancel_we", wb_we_o, 0);
         check("cancel_stall", stall_req_o, 0);
         check("cancel_hold", wb_data_o, last_data);
         next_cycle();
         @(negedge clk);
         check("cancel_once", mul_cancel_o, 0);
         check("cancel_we2", wb_we_o, 0);
         return;
      end

      next_cycle();
      mul_stop_i = 1'b0;
      if (flush_at == lat + 1) flush_i = 1'b1;
      @(negedge clk);
      if (flush_at == lat + 1) begin
         check("done_flush_we", wb_we_o, 0);
         check("done_flush_hold", wb_data_o, last_data);
      end else begin
         check("wb_we", wb_we_o, 1);
         check("wb_data", wb_data_o, exp);
         check("wb_rd", wb_rd_addr_o, rd);
         last_data = exp; last_rd = rd;
      end
      check("done_stall", stall_req_o, 0);
      check("done_start", mul_start_o, 0);
      ent_vld = 1'b1; ent_a = a; ent_b = b; ent_cls = op_cls(op);

      next_cycle();
      ex_mul_req_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      check("we_single", wb_we_o, 0);
      check("data_hold", wb_data_o, last_data);
      check("rd_hold", wb_rd_addr_o, last_rd);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd5;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd10;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      ex_mul_req_i = 1'b0; ex_mul_op_i = '0; ex_op1_i = '0; ex_op2_i = '0; ex_rd_addr_i = '0;
      flush_i = 1'b0; mul_stop_i = 1'b0; mul_res_l_i = '0; mul_res_h_i = '0;
      ent_vld = 1'b0; ent_a = '0; ent_b = '0; ent_cls = 0; last_data = '0; last_rd = '0;

      @(negedge clk);
      check("rst_start", mul_start_o, 0);
      check("rst_cancel", mul_cancel_o, 0);
      check("rst_signed", mul_signed_o, 0);
      check("rst_op1", mul_op1_o, 0);
      check("rst_op2", mul_op2_o, 0);
      check("rst_stall", stall_req_o, 0);
      check("rst_we", wb_we_o, 0);
      check("rst_rd", wb_rd_addr_o, 0);
      check("rst_data", wb_data_o, 0);
      next_cycle();
      rst = 1'b0;

      run_op(OP_MUL,    32'd5,         32'd10,        5'd3,  4, 0);
      run_op(OP_MULH,   32'hFFFF_FFFD, 32'd7,         5'd7,  3, 0);
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  2, 0);
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 5, 0);
      run_op(OP_MULH,   32'd123,       32'd456,       5'd4,  6, 3);
      run_op(OP_MULHU,  32'd77,        32'd88,        5'd5,  3, 3);
      run_op(OP_MUL,    32'd99,        32'd11,        5'd6,  2, 3);
      run_op(OP_MULH,   32'd5,         32'd10,        5'd8,  4, 0);
      run_op(OP_MUL,    32'd5,         32'd10,        5'd10, 4, 0);

      // Reset in the middle of an operation: silent abort, entry and outputs cleared.
      next_cycle();
      ex_mul_req_i = 1'b1; ex_mul_op_i = OP_MULHU; ex_op1_i = 32'd3; ex_op2_i = 32'd4; ex_rd_addr_i = 5'd2;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("pre_rst_start", mul_start_o, 1);
      next_cycle();
      ex_mul_req_i = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("midrst_start", mul_start_o, 0);
      check("midrst_cancel", mul_cancel_o, 0);
      check("midrst_data", wb_data_o, 0);
      check("midrst_op1", mul_op1_o, 0);
      next_cycle();
      rst = 1'b0; ent_vld = 1'b0; last_data = '0; last_rd = '0;
      @(negedge clk);
      check("postrst_cancel", mul_cancel_o, 0);
      check("postrst_stall", stall_req_o, 0);

      begin
         logic [31:0] a, b;
         a = 32'd5; b = 32'd10;
         for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int         lat, fl;
            op  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
               a = pick_operand();
               b = pick_operand();
            end
            lat = $urandom_range(1, 5);
            fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + 1) : 0;
            run_op(op, a, b, 5'($urandom_range(0, 31)), lat, fl);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
